// File: rtl/drive_sequencer.sv
// drive_sequencer: shared-PWM H-bridge drive FSM with collision pause and tone-commanded junction manoeuvres
module drive_sequencer #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int PWM_FREQ     = 80,
  parameter int FULL_PCT     = 80,
  parameter int VEER_PCT     = 40,
  parameter int TURN_PERIODS = 40,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir,
  input  logic       col_detect,
  input  logic       td_en,
  input  logic [1:0] td_dir,
  output logic       hb_en_a,
  output logic       hb_en_b,
  output logic       hb_in1,
  output logic       hb_in2,
  output logic       hb_in3,
  output logic       hb_in4,
  output logic [2:0] state,
  output logic       pwm_tick
);
  localparam int PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int FULL_C = FULL_PCT > 80 ? 80 : FULL_PCT;
  localparam int VEER_C = VEER_PCT > FULL_C ? FULL_C : VEER_PCT;
  localparam logic [CNT_W-1:0] FULL_ON = CNT_W'(PERIOD * FULL_C / 100);
  localparam logic [CNT_W-1:0] VEER_ON = CNT_W'(PERIOD * VEER_C / 100);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam int TW = $clog2(TURN_PERIODS + 1);

  typedef enum logic [2:0] {FWD = 3'd0, REV = 3'd1, COLL = 3'd2, JUNC = 3'd3, TURN = 3'd4} st_e;

  st_e st_q, st_d;
  logic [CNT_W-1:0] cnt_q;
  logic rev_q, rev_d;
  logic [TW-1:0] tc_q, tc_d;
  logic [1:0] td_q, td_d;
  logic en_a_q, en_a_d, en_b_q, en_b_d;
  logic [3:0] in_q, in_d;
  logic full, veer;
  logic unused_dir;

  assign unused_dir = ^dir[1:0];
  assign pwm_tick = cnt_q == LAST;
  assign full = cnt_q < FULL_ON;
  assign veer = cnt_q < VEER_ON;
  assign state = st_q;
  assign {hb_en_a, hb_en_b} = {en_a_q, en_b_q};
  assign {hb_in1, hb_in2, hb_in3, hb_in4} = in_q;

  always_comb begin
    st_d = st_q;
    rev_d = rev_q;
    tc_d = tc_q;
    td_d = td_q;
    case (st_q)
      FWD, REV: st_d = col_detect ? COLL : dir[3:2] == 2'b11 ? JUNC : st_q;
      COLL: st_d = col_detect ? COLL : rev_q ? REV : FWD;
      JUNC: if (td_en) begin
        td_d = td_dir;
        tc_d = '0;
        rev_d = rev_q | (td_dir == 2'b11);
        st_d = td_dir == 2'b11 ? REV : TURN;
      end
      TURN: begin
        tc_d = tc_q + TW'(pwm_tick);
        st_d = col_detect ? COLL : tc_d == TW'(TURN_PERIODS) ? (rev_q ? REV : FWD) : TURN;
      end
      default: st_d = FWD;
    endcase
    // Outputs are decoded from the next state so pins and state change on the same edge
    in_d = in_q;
    en_a_d = 1'b0;
    en_b_d = 1'b0;
    case (st_d)
      FWD: begin
        in_d = 4'b0110;
        en_a_d = dir[3:2] == 2'b01 ? veer : full;
        en_b_d = dir[3:2] == 2'b10 ? veer : full;
      end
      REV: begin
        in_d = 4'b1001;
        en_a_d = dir[3:2] == 2'b10 ? veer : full;
        en_b_d = dir[3:2] == 2'b01 ? veer : full;
      end
      JUNC: in_d = 4'b0000;
      TURN: begin
        in_d = td_d == 2'b01 ? 4'b1010 : td_d == 2'b10 ? 4'b0101 : 4'b0110;
        en_a_d = full;
        en_b_d = full;
      end
      default: in_d = in_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      st_q <= FWD;
      rev_q <= 1'b0;
      tc_q <= '0;
      td_q <= '0;
      en_a_q <= 1'b0;
      en_b_q <= 1'b0;
      in_q <= '0;
    end else begin
      cnt_q <= pwm_tick ? '0 : cnt_q + 1'b1;
      st_q <= st_d;
      rev_q <= rev_d;
      tc_q <= tc_d;
      td_q <= td_d;
      en_a_q <= en_a_d;
      en_b_q <= en_b_d;
      in_q <= in_d;
    end
  end
endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: scoreboard bench for drive_sequencer (PERIOD 10, FULL_ON 8, VEER_ON 4, 3 turn periods)
module tb_drive_sequencer;
  logic clk = 1'b0;
  logic rst, col_detect, td_en;
  logic [3:0] dir;
  logic [1:0] td_dir;
  logic hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4, pwm_tick;
  logic [2:0] state;
  logic [5:0] hb;
  int total = 0, bad = 0;

  assign hb = {hb_en_a, hb_en_b, hb_in1, hb_in2, hb_in3, hb_in4};

  drive_sequencer #(.CLK_FREQ(1000), .PWM_FREQ(100), .FULL_PCT(80), .VEER_PCT(40),
                    .TURN_PERIODS(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .dir(dir), .col_detect(col_detect), .td_en(td_en), .td_dir(td_dir),
    .hb_en_a(hb_en_a), .hb_en_b(hb_en_b), .hb_in1(hb_in1), .hb_in2(hb_in2),
    .hb_in3(hb_in3), .hb_in4(hb_in4), .state(state), .pwm_tick(pwm_tick));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pushes the expected {state, en_a, en_b, in1..4, tick} for each edge
  int m_cnt = 0, m_st = 0, m_tc = 0, nst;
  bit m_rev, m_ea, m_eb, full, veer, tick;
  bit [1:0] m_td;
  bit [3:0] m_in;
  logic [9:0] exp_q[$];

  initial forever begin
    @(posedge clk);
    full = m_cnt < 8;
    veer = m_cnt < 4;
    tick = m_cnt == 9;
    if (rst) begin
      m_cnt = 0; m_st = 0; m_tc = 0; m_rev = 0; m_td = 0; m_ea = 0; m_eb = 0; m_in = 0;
    end else begin
      nst = m_st;
      if (m_st != 2 && m_st != 3 && col_detect) nst = 2;
      else if (m_st == 2 && !col_detect) nst = int'(m_rev);
      else if (m_st < 2 && dir[3:2] == 2'b11) nst = 3;
      else if (m_st == 3 && td_en) begin
        m_td = td_dir;
        m_tc = 0;
        if (td_dir == 2'b11) begin m_rev = 1; nst = 1; end else nst = 4;
      end else if (m_st == 4) begin
        m_tc += int'(tick);
        if (m_tc == 3) nst = int'(m_rev);
      end
      m_ea = 0;
      m_eb = 0;
      case (nst)
        0: begin m_in = 4'b0110; m_ea = dir[3:2] == 2'b01 ? veer : full; m_eb = dir[3:2] == 2'b10 ? veer : full; end
        1: begin m_in = 4'b1001; m_ea = dir[3:2] == 2'b10 ? veer : full; m_eb = dir[3:2] == 2'b01 ? veer : full; end
        3: m_in = 4'b0000;
        4: begin m_in = m_td == 1 ? 4'b1010 : m_td == 2 ? 4'b0101 : 4'b0110; m_ea = full; m_eb = full; end
        default: ;
      endcase
      m_st = nst;
      m_cnt = tick ? 0 : m_cnt + 1;
    end
    exp_q.push_back({3'(m_st), m_ea, m_eb, m_in, m_cnt == 9});
  end

  initial forever begin
    logic [9:0] e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_state", state, e[9:7]);
      check("sb_hb", hb, e[6:1]);
      check("sb_tick", pwm_tick, e[0]);
    end
  end

  task automatic run(input int n, output int ca, output int cb, output int ct);
    ca = 0; cb = 0; ct = 0;
    repeat (n) begin
      @(negedge clk);
      ca += hb_en_a; cb += hb_en_b; ct += pwm_tick;
    end
  endtask

  task automatic junction(input logic [1:0] cmd);
    dir = 4'b1100;
    @(negedge clk);
    dir = 4'b0000;
    td_en = 1'b1;
    td_dir = cmd;
    @(negedge clk);
    td_en = 1'b0;
  endtask

  task automatic wait_turn(output int n);
    n = 0;
    while (state == 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int a, b, t, n;
    rst = 1; dir = 0; col_detect = 0; td_en = 0; td_dir = 0;
    repeat (2) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_hb", hb, 0);
    check("rst_tick", pwm_tick, 0);
    rst = 0;
    run(30, a, b, t);
    check("fwd_duty_a", a, 24);
    check("fwd_duty_b", b, 24);
    check("fwd_ticks", t, 3);
    check("fwd_in", hb[3:0], 4'b0110);
    check("fwd_state", state, 0);
    dir = 4'b0100;
    run(30, a, b, t);
    check("veerl_duty_a", a, 12);
    check("veerl_duty_b", b, 24);
    dir = 4'b1000;
    run(30, a, b, t);
    check("veerr_duty_a", a, 24);
    check("veerr_duty_b", b, 12);
    dir = 4'b0000;
    col_detect = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("coll_state", state, 2);
      check("coll_en", hb[5:4], 0);
      check("coll_in_hold", hb[3:0], 4'b0110);
    end
    col_detect = 0;
    @(negedge clk);
    check("coll_resume", state, 0);
    dir = 4'b1100;
    @(negedge clk);
    check("junc_state", state, 3);
    check("junc_brake", hb, 0);
    dir = 4'b0000;
    col_detect = 1;
    repeat (3) @(negedge clk);
    check("junc_ignores_col", state, 3);
    col_detect = 0;
    td_en = 1; td_dir = 2'b01;
    @(negedge clk);
    td_en = 0;
    check("left_state", state, 4);
    check("left_in", hb[3:0], 4'b1010);
    wait_turn(n);
    check("left_len_ok", int'(n >= 21 && n <= 30), 1);
    check("left_exit", state, 0);
    junction(2'b11);
    check("back_state", state, 1);
    check("back_in", hb[3:0], 4'b1001);
    run(20, a, b, t);
    check("rev_duty_a", a, 16);
    dir = 4'b0100;
    run(20, a, b, t);
    check("rev_veer_a", a, 16);
    check("rev_veer_b", b, 8);
    junction(2'b00);
    check("straight_state", state, 4);
    check("straight_in", hb[3:0], 4'b0110);
    wait_turn(n);
    check("straight_exit_rev", state, 1);
    col_detect = 1; dir = 4'b1100;
    @(negedge clk);
    check("simul_state", state, 2);
    check("simul_in_hold", hb[3:0], 4'b1001);
    dir = 4'b0000;
    repeat (2) @(negedge clk);
    col_detect = 0;
    @(negedge clk);
    check("rev_resume", state, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    junction(2'b10);
    check("right_in", hb[3:0], 4'b0101);
    repeat (5) @(negedge clk);
    col_detect = 1;
    @(negedge clk);
    check("turn_coll", state, 2);
    col_detect = 0;
    @(negedge clk);
    check("turn_abandon", state, 0);
    junction(2'b01);
    repeat (14) @(negedge clk);
    check("pre_rst_turn", state, 4);
    rst = 1;
    @(negedge clk);
    check("midrst_state", state, 0);
    check("midrst_hb", hb, 0);
    check("midrst_tick", pwm_tick, 0);
    rst = 0;
    run(10, a, b, t);
    check("post_rst_state", state, 0);
    check("post_rst_duty", a, 8);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
